// File: rtl/a8_bus_sampler_if.sv
// a8_bus_sampler_if: Atari cartridge-bus pins plus the sampled bus-cycle strobes and latches
interface a8_bus_sampler_if;
  logic        a8_clk;
  logic [15:0] a8_addr;
  logic [7:0]  a8_data;
  logic        a8_rw_n;
  logic        a8_halt_n;
  logic        a8_ref_n;
  logic        cyc_start;
  logic        addr_stb;
  logic [15:0] bus_addr;
  logic        bus_rw_n;
  logic        bus_dma;
  logic        wr_stb;
  logic [7:0]  wr_data;
  logic        cyc_err;
  logic        stalled;
  modport master (
    output a8_clk, a8_addr, a8_data, a8_rw_n, a8_halt_n, a8_ref_n,
    input  cyc_start, addr_stb, bus_addr, bus_rw_n, bus_dma, wr_stb, wr_data, cyc_err, stalled
  );
  modport slave (
    input  a8_clk, a8_addr, a8_data, a8_rw_n, a8_halt_n, a8_ref_n,
    output cyc_start, addr_stb, bus_addr, bus_rw_n, bus_dma, wr_stb, wr_data, cyc_err, stalled
  );
endinterface

// File: rtl/a8_bus_sampler.sv
// a8_bus_sampler: syncs Atari PHI2 into clk and times address/write-data capture from each falling edge
module a8_bus_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_SAMPLE = 20,
  parameter int DATA_SAMPLE = 46,
  parameter int CYC_TIMEOUT = 80
) (
  input logic clk,
  input logic a8_rst_n,
  a8_bus_sampler_if.slave bus
);
  localparam logic [6:0] A_LAST = 7'(ADDR_SAMPLE - 1);
  localparam logic [6:0] D_LAST = 7'(DATA_SAMPLE - 1);
  localparam logic [6:0] T_LAST = 7'(CYC_TIMEOUT - 1);
  localparam logic [6:0] T_MAX  = 7'(CYC_TIMEOUT);
  typedef enum logic [1:0] {IDLE, ADDR_WAIT, DATA_WAIT, DONE} state_t;
  state_t state;
  logic [1:0] rst_q;
  logic rst_n;
  logic [SYNC_STAGES-1:0] sync;
  logic prev, fall, refc;
  logic [6:0] cnt;
  always_ff @(posedge clk or negedge a8_rst_n)
    if (!a8_rst_n) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_n = rst_q[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.a8_clk};
      prev <= sync[SYNC_STAGES-1];
    end
  assign fall = prev & ~sync[SYNC_STAGES-1];
  // a new fall always wins: it aborts any pending sample point or timeout in the same clk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      refc <= 1'b0;
      bus.cyc_start <= 1'b0;
      bus.addr_stb <= 1'b0;
      bus.wr_stb <= 1'b0;
      bus.cyc_err <= 1'b0;
      bus.stalled <= 1'b1;
      bus.bus_addr <= '0;
      bus.bus_rw_n <= 1'b1;
      bus.bus_dma <= 1'b0;
      bus.wr_data <= '0;
    end else begin
      bus.cyc_start <= fall;
      bus.addr_stb <= 1'b0;
      bus.wr_stb <= 1'b0;
      bus.cyc_err <= 1'b0;
      cnt <= fall ? '0 : (cnt == T_MAX) ? cnt : cnt + 7'd1;
      if (fall) begin
        bus.cyc_err <= (state == ADDR_WAIT) || (state == DATA_WAIT);
        bus.stalled <= 1'b0;
        state <= ADDR_WAIT;
      end else if (state != IDLE && cnt == T_LAST) begin
        bus.cyc_err <= 1'b1;
        bus.stalled <= 1'b1;
        state <= IDLE;
      end else if (state == ADDR_WAIT && cnt == A_LAST) begin
        state <= DATA_WAIT;
        refc <= ~bus.a8_ref_n;
        if (bus.a8_ref_n) begin
          bus.addr_stb <= 1'b1;
          bus.bus_addr <= bus.a8_addr;
          bus.bus_rw_n <= bus.a8_rw_n;
          bus.bus_dma <= ~bus.a8_halt_n;
        end
      end else if (state == DATA_WAIT && cnt == D_LAST) begin
        state <= DONE;
        bus.wr_data <= bus.a8_data;
        bus.wr_stb <= ~refc & ~bus.bus_rw_n & bus.a8_ref_n;
      end
    end
endmodule

// File: tb/tb_a8_bus_sampler.sv
// tb_a8_bus_sampler: directed table, corner sequences and a randomized event-level reference model
module tb_a8_bus_sampler;
  localparam int N = 2000;
  logic clk = 1'b0;
  logic a8_rst_n = 1'b1;
  a8_bus_sampler_if bus ();
  a8_bus_sampler dut (.clk(clk), .a8_rst_n(a8_rst_n), .bus(bus));
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  int n_start, n_addr, n_wr, n_err;
  logic [15:0] cap_addr, last_addr;
  logic [7:0] cap_wd;
  logic cap_rw, cap_dma, st_pre, st_start;
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw, rf, hl;
    int          e_addr, e_wr;
    logic        e_dma;
  } vec_t;
  vec_t tbl[7];
  logic        pin_d[N];
  logic [15:0] ad[N];
  logic [7:0]  dd[N];
  logic        rw_d[N], ref_d[N], hl_d[N];
  logic [30:0] obs[N];
  logic        e_start[N], e_astb[N], e_wstb[N], e_err[N], st_clr[N], st_set[N], dl[N];
  logic [15:0] la[N];
  logic        lrw[N], ldma[N];
  logic [7:0]  lwd[N];
  int bl[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic c, input logic [15:0] a, input logic [7:0] d, input logic rw, rf, hl);
    bus.a8_clk = c;
    bus.a8_addr = a;
    bus.a8_data = d;
    bus.a8_rw_n = rw;
    bus.a8_ref_n = rf;
    bus.a8_halt_n = hl;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive(1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 1'b1);
    end
  endtask
  task automatic phi_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw, rf, hl, input int len);
    n_start = 0; n_addr = 0; n_wr = 0; n_err = 0; st_pre = 1'bx; st_start = 1'bx;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (bus.cyc_start) begin n_start++; st_start = bus.stalled; end
      if (bus.addr_stb) begin
        n_addr++; cap_addr = bus.bus_addr; cap_rw = bus.bus_rw_n; cap_dma = bus.bus_dma;
      end
      if (bus.wr_stb) begin n_wr++; cap_wd = bus.wr_data; end
      if (bus.cyc_err) n_err++;
      if (k == 2) st_pre = bus.stalled;
      drive(k < len / 2 ? 1'b0 : 1'b1, a, d, rw, rf, hl);
    end
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_strobes"}, {bus.cyc_start, bus.addr_stb, bus.wr_stb, bus.cyc_err}, 0);
    chk({nm, "_bus_addr"}, bus.bus_addr, 16'h0);
    chk({nm, "_wr_data"}, bus.wr_data, 8'h0);
    chk({nm, "_bus_rw_n"}, bus.bus_rw_n, 1'b1);
    chk({nm, "_bus_dma"}, bus.bus_dma, 1'b0);
    chk({nm, "_stalled"}, bus.stalled, 1'b1);
  endtask
  initial begin
    tbl[0] = '{16'hD604, 8'h05, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0};
    tbl[1] = '{16'hD604, 8'h77, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0};
    tbl[2] = '{16'h0607, 8'h12, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0};
    tbl[3] = '{16'h0639, 8'h34, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0};
    tbl[4] = '{16'hD601, 8'hAA, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
    tbl[5] = '{16'h1234, 8'h56, 1'b1, 1'b1, 1'b0, 1, 0, 1'b1};
    tbl[6] = '{16'hD605, 8'h10, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0};
    bl = '{20, 21, 46, 47, 80, 81};
    drive(1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 1'b1);
    #2 a8_rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("por");
    idle(2);
    a8_rst_n = 1'b1;
    idle(10);
    last_addr = 16'h0;
    for (int i = 0; i < 7; i++) begin
      phi_cycle(tbl[i].a, tbl[i].d, tbl[i].rw, tbl[i].rf, tbl[i].hl, 56);
      chk($sformatf("row%0d_cyc_start", i), n_start, 1);
      chk($sformatf("row%0d_cyc_err", i), n_err, 0);
      chk($sformatf("row%0d_addr_stb", i), n_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_wr_stb", i), n_wr, tbl[i].e_wr);
      if (tbl[i].e_addr != 0) begin
        last_addr = tbl[i].a;
        chk($sformatf("row%0d_rw_n", i), cap_rw, tbl[i].rw);
        chk($sformatf("row%0d_dma", i), cap_dma, tbl[i].e_dma);
      end
      if (tbl[i].e_wr != 0) chk($sformatf("row%0d_wr_data", i), cap_wd, tbl[i].d);
      chk($sformatf("row%0d_bus_addr", i), bus.bus_addr, last_addr);
    end
    phi_cycle(16'hD604, 8'h05, 1'b0, 1'b1, 1'b1, 30);
    chk("short1_start", n_start, 1);
    chk("short1_addr_stb", n_addr, 1);
    chk("short1_wr_stb", n_wr, 0);
    phi_cycle(16'hD605, 8'h10, 1'b0, 1'b1, 1'b1, 56);
    chk("short2_cyc_err", n_err, 1);
    chk("short2_start", n_start, 1);
    chk("short2_addr", cap_addr, 16'hD605);
    chk("short2_wr_stb", n_wr, 1);
    chk("short2_wr_data", cap_wd, 8'h10);
    n_err = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.cyc_err) n_err++;
      if (k == 26) chk("stall_before", bus.stalled, 1'b0);
      if (k == 27) chk("stall_at_timeout", bus.stalled, 1'b1);
      drive(1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 1'b1);
    end
    chk("stall_cyc_err_once", n_err, 1);
    chk("stall_level", bus.stalled, 1'b1);
    phi_cycle(16'h0607, 8'h00, 1'b1, 1'b1, 1'b1, 56);
    chk("resume_pre_stalled", st_pre, 1'b1);
    chk("resume_stalled_at_start", st_start, 1'b0);
    chk("resume_start", n_start, 1);
    chk("resume_cyc_err", n_err, 0);
    chk("resume_addr", cap_addr, 16'h0607);
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (k == 33) begin
        chk("pre_rst_addr", bus.bus_addr, 16'hD604);
        chk("pre_rst_stalled", bus.stalled, 1'b0);
        a8_rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
      end
      drive(k < 28 ? 1'b0 : 1'b1, 16'hD604, 8'h05, 1'b0, 1'b1, 1'b1);
    end
    idle(3);
    a8_rst_n = 1'b1;
    idle(6);
    for (int p = 0; p < N; ) begin
      int len, r;
      logic [15:0] a;
      logic [7:0] d;
      logic rw, rf, hl;
      r = $urandom_range(0, 9);
      len = r < 6 ? $urandom_range(54, 58) : r == 6 ? $urandom_range(4, 45) : r == 7 ? $urandom_range(82, 130) : bl[$urandom_range(0, 5)];
      if (p == 0) len = 10;
      a = $urandom_range(0, 1) ? {8'hD6, 8'($urandom)} : 16'($urandom);
      d = 8'($urandom);
      rw = 1'($urandom);
      rf = ($urandom_range(0, 7) != 0);
      hl = ($urandom_range(0, 5) != 0);
      for (int j = 0; j < len && p < N; j++) begin
        pin_d[p] = (p < 10) ? 1'b1 : (j < len / 2 ? 1'b0 : 1'b1);
        ad[p] = a; dd[p] = d; rw_d[p] = rw; ref_d[p] = rf; hl_d[p] = hl;
        p++;
      end
    end
    for (int m = 0; m < N; m++) begin
      @(negedge clk);
      obs[m] = {bus.cyc_start, bus.addr_stb, bus.wr_stb, bus.cyc_err, bus.stalled,
                bus.bus_addr, bus.bus_rw_n, bus.bus_dma, bus.wr_data};
      drive(pin_d[m], ad[m], dd[m], rw_d[m], ref_d[m], hl_d[m]);
    end
    begin
      int ev[$];
      logic st, brw, bdma;
      logic [15:0] ba;
      logic [7:0] wd;
      for (int m = 0; m < N; m++) begin
        e_start[m] = 0; e_astb[m] = 0; e_wstb[m] = 0; e_err[m] = 0;
        st_clr[m] = 0; st_set[m] = 0; dl[m] = 0;
      end
      for (int n = 1; n < N; n++) if (pin_d[n - 1] && !pin_d[n]) ev.push_back(n + 3);
      for (int i = 0; i < ev.size(); i++) begin
        int e, en, ta, td, tt;
        e = ev[i];
        en = (i + 1 < ev.size()) ? ev[i + 1] : 32'h3fffffff;
        ta = e + 20; td = e + 46; tt = e + 80;
        if (e < N) begin
          e_start[e] = 1; st_clr[e] = 1;
          if (i > 0 && e - ev[i - 1] <= 46) e_err[e] = 1;
        end
        if (en > ta && ta < N && ref_d[ta - 1]) begin
          e_astb[ta] = 1; la[ta] = ad[ta - 1]; lrw[ta] = rw_d[ta - 1]; ldma[ta] = !hl_d[ta - 1];
        end
        if (en > td && td < N) begin
          dl[td] = 1; lwd[td] = dd[td - 1];
          e_wstb[td] = ref_d[ta - 1] && !rw_d[ta - 1] && ref_d[td - 1];
        end
        if (en > tt && tt < N) begin e_err[tt] = 1; st_set[tt] = 1; end
      end
      st = 1; ba = 0; brw = 1; bdma = 0; wd = 0;
      for (int m = 0; m < N; m++) begin
        if (st_clr[m]) st = 0;
        if (st_set[m]) st = 1;
        if (e_astb[m]) begin ba = la[m]; brw = lrw[m]; bdma = ldma[m]; end
        if (dl[m]) wd = lwd[m];
        chk($sformatf("rand@%0d", m), 32'(obs[m]),
            32'({e_start[m], e_astb[m], e_wstb[m], e_err[m], st, ba, brw, bdma, wd}));
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
